gate_controller: RTL

GATE_CONTROLLER -- requirements
Module: gate_controller

---
 rtl/gate_pkg.sv | 22 ++
 rtl/gate_timer.sv | 28 ++
 rtl/gate_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the parking-gate controller.
//   gate_state_e  - FSM state encoding (IDLE/OPEN_ENT/OPEN_SAI/CLOSE)
//   GATE_*        - default values for the gate_controller parameters
//   max2()        - helper used to size the shared timer
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OPEN_ENT = 2'b01,
    OPEN_SAI = 2'b10,
    CLOSE    = 2'b11
  } gate_state_e;

  localparam int GATE_CAPACITY     = 63;
  localparam int GATE_OPEN_TIMEOUT = 200;
  localparam int GATE_CLOSE_HOLD   = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// gate_timer: loadable down-counter with a done flag.
//   clk, reset   - clock, async active-low reset
//   load_i       - load load_val_i this edge (takes priority over counting)
//   load_val_i   - value to load
//   done_o       - high while the count is zero
// Loading N gives done_o after N further edges, so loading T-1 on the edge
// that enters a state makes that state last exactly T cycles.
module gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/gate_controller.sv
// gate_controller: arbitrates entry/exit lanes of a car park barrier.
//   clk, reset            - clock, async active-low reset
//   req_ent, req_sai      - lane requests (level), sampled only in IDLE
//   pass_sensor           - vehicle has cleared the barrier
//   occupancy             - current car count
//   alerta, emergencia    - flood status; block entry (emergencia also aborts
//                           an open entry)
//   grant_ent, grant_sai  - lane being served (registered)
//   gate_open             - barrier open command (registered)
//   inc, dec              - one-cycle counter pulses on a completed passage
//   full                  - occupancy >= CAPACITY (combinational)
//   denied_cnt            - refused entry requests, saturating; only counts
//                           when GATE_STATS_EN is defined, otherwise tied to 0
module gate_controller
  import gate_pkg::*;
#(
  parameter int CAPACITY     = GATE_CAPACITY,
  parameter int OPEN_TIMEOUT = GATE_OPEN_TIMEOUT,
  parameter int CLOSE_HOLD   = GATE_CLOSE_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_ent,
  input  logic       req_sai,
  input  logic       pass_sensor,
  input  logic [5:0] occupancy,
  input  logic       alerta,
  input  logic       emergencia,
  output logic       grant_ent,
  output logic       grant_sai,
  output logic       gate_open,
  output logic       inc,
  output logic       dec,
  output logic       full,
  output logic [7:0] denied_cnt
);

  localparam int TW = $clog2(max2(OPEN_TIMEOUT, CLOSE_HOLD) + 1);

  gate_state_e state_q;
  logic        grant_ent_q, grant_sai_q, gate_open_q, inc_q, dec_q;
  logic        last_sai_q;   // 1: exit lane was granted last
  logic        ent_ok, pick_ent, start, open_exit, tmr_done, tmr_load;
  logic [TW-1:0] tmr_val;

  assign full     = (32'(occupancy) >= 32'(CAPACITY));
  assign ent_ok   = req_ent & ~full & ~alerta & ~emergencia;
  // On a tie the lane not served last wins.
  assign pick_ent = ent_ok & (~req_sai | last_sai_q);
  assign start    = (state_q == IDLE) & (ent_ok | req_sai);
  // Emergencia aborts only the entry opening; the exit lane keeps running.
  assign open_exit = ((state_q == OPEN_ENT) & (emergencia | pass_sensor | tmr_done)) |
                     ((state_q == OPEN_SAI) & (pass_sensor | tmr_done));

  // One timer: opening timeout, then reloaded for the close hold.
  assign tmr_load = start | open_exit;
  assign tmr_val  = start ? TW'(OPEN_TIMEOUT - 1) : TW'(CLOSE_HOLD - 1);

  gate_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_ent_q <= 1'b0;
      grant_sai_q <= 1'b0;
      gate_open_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      last_sai_q  <= 1'b1;
    end else begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          gate_open_q <= 1'b1;
          if (pick_ent) begin
            state_q     <= OPEN_ENT;
            grant_ent_q <= 1'b1;
            last_sai_q  <= 1'b0;
          end else begin
            state_q     <= OPEN_SAI;
            grant_sai_q <= 1'b1;
            last_sai_q  <= 1'b1;
          end
        end
        OPEN_ENT: if (open_exit) begin
          state_q     <= CLOSE;
          grant_ent_q <= 1'b0;
          gate_open_q <= 1'b0;
          inc_q       <= pass_sensor & ~emergencia;
        end
        OPEN_SAI: if (open_exit) begin
          state_q     <= CLOSE;
          grant_sai_q <= 1'b0;
          gate_open_q <= 1'b0;
          dec_q       <= pass_sensor;
        end
        CLOSE: if (tmr_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_ent = grant_ent_q;
  assign grant_sai = grant_sai_q;
  assign gate_open = gate_open_q;
  assign inc       = inc_q;
  assign dec       = dec_q;

`ifdef GATE_STATS_EN
  logic [7:0] denied_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) denied_q <= '0;
    else if ((state_q == IDLE) && req_ent && !ent_ok && (denied_q != 8'hFF))
      denied_q <= denied_q + 8'd1;
  end
  assign denied_cnt = denied_q;
`else
  assign denied_cnt = 8'd0;
`endif

endmodule
